seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
- Runtime-programmable serial pattern detector, generalising the fixed 0110 Mealy detector.
- Matches any pattern of 1..MAX_LEN bits on a qualified serial input.
- Overlapping or non-overlapping mode is selectable per configuration.
- Provides a Mealy match flag, a registered copy of it, and a saturating match counter for the serial front-end status logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width
LEN_W, $clog2(MAX_LEN+1), width of pat_len (derived, do not override)

Ports:
clk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
x  in  1  serial data bit
x_valid  in  1  x is sampled only when 1
cfg_load  in  1  one-cycle pulse: capture cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 = first bit received, bit 0 = last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  in  1  synchronous clear of match_count
z  out  1  Mealy match: combinational, same cycle as final pattern bit
z_q  out  1  z registered (one cycle later)
match_count  out  CNT_W  saturating count of matches
cfg_err  out  1  loaded cfg_len illegal; detector disabled

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- On reset: pattern=0, len=0, overlap=0, cfg_err=1 (len 0 is illegal), hist=0, fill=0, z_q=0, match_count=0.
- z=0 throughout reset.
- State registers:
  - pattern_r, len_r, ovl_r (configuration shadow).
  - hist[MAX_LEN-1:0]: last accepted bits, newest at bit 0.
  - fill: accepted bits since last clear, saturating at MAX_LEN.
- Configuration load (cfg_load=1):
  - Shadow regs take the cfg_* values; hist and fill clear to 0.
  - cfg_err <= (cfg_len==0 || cfg_len>MAX_LEN).
  - match_count is not affected.
  - x in the same cycle is discarded, and z=0.
- Candidate window: cand = {hist[MAX_LEN-2:0], x}.
- Match condition: z = x_valid & ~cfg_load & ~cfg_err & (fill+1 >= len_r) & ((cand ^ pattern_r) & mask == 0).
  - mask has its low len_r bits set.
  - Comparison is purely combinational from current x; there is no pipeline delay on z.
- Accepted bit (x_valid=1, cfg_load=0):
  - hist <= cand.
  - If z=1 and ovl_r=0: fill <= 0 and hist <= 0, so the next match needs a full fresh len_r bits.
  - Otherwise fill <= min(fill+1, MAX_LEN).
- x_valid=0: hist, fill hold; z=0; z_q <= 0 on that edge.
- z_q <= z every cycle.
- match_count:
  - cnt_clr=1 -> 0. cnt_clr wins over a simultaneous match; that match is not counted.
  - Else if z=1 and count < 2^CNT_W-1 -> count+1.
  - At all-ones the count holds.
- cfg_err=1: z, z_q stay 0; hist and fill still update, harmless.
- len_r=1: every accepted bit equal to pattern_r[0] matches.
  - Non-overlap mode gives the same result for len 1.
- Reset asserted mid-stream clears all state immediately; partial match is lost.
  - First compare after deassertion needs len_r new bits and a new cfg_load, since the config is reset.

Test Plan:
- Overlapping mode:
  - Stimulus: after reset, cfg_load with pattern=8'b0000_0110, len=4, overlap=1; stream 0,1,1,0,1,1,0 with x_valid=1 each cycle.
  - Required: z=1 on bits 4 and 7 only; z_q on the following cycles; match_count=2.
- Non-overlapping mode:
  - Stimulus: pattern=2'b11, len=2, overlap=0; stream 1,1,1,1,1.
  - Required: z on bits 2 and 4; count=2.
  - Repeat with overlap=1 -> z on bits 2,3,4,5; count=4.
- Gaps in x_valid:
  - Stimulus: pattern 0110 len 4; bits 0,1,1,0 with x_valid=0 idle cycles interleaved.
  - Required: z only in the cycle the final 0 is valid; no z during idle cycles.
- Illegal config and reload:
  - Stimulus: cfg_len=0, then cfg_len=9 with MAX_LEN=8.
  - Required: cfg_err=1 and z never asserts on a matching stream.
  - Then reload len=3 pattern 101 -> cfg_err=0 and detection resumes.
  - A cfg_load coincident with a would-be final bit gives z=0 and that bit discarded.
- Counter saturation and clear (CNT_W=2, len 1, pattern 1):
  - Stimulus: 5 consecutive 1s.
  - Required: count goes 1,2,3,3,3.
  - cnt_clr concurrent with a match -> count=0.
- Reset mid-pattern:
  - Stimulus: after 0,1,1 of 0110, pulse reset low asynchronously, between clock edges.
  - Required: outputs and count clear at once; after deassertion, cfg_err=1 until a new cfg_load.
  - Then 0 alone gives no z; the full 0110 is required.

Source files
------------

// File: rtl/seq_detector_prog_if.sv
// ----------------------------------------------------------------------------
// seq_detector_prog_if
//   Bundle of the serial-data, configuration and status signals of the
//   programmable sequence detector.
//
//   Data side   : x, x_valid
//   Config side : cfg_load, cfg_pattern, cfg_len, cfg_overlap
//   Counter     : cnt_clr (in), match_count (out)
//   Status      : z (Mealy match), z_q (registered match), cfg_err
//
//   master modport : the block that feeds bits/config and reads status
//   slave  modport : the detector itself
// ----------------------------------------------------------------------------
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic                 x;
    logic                 x_valid;
    logic                 cfg_load;
    logic [MAX_LEN-1:0]   cfg_pattern;
    logic [LEN_W-1:0]     cfg_len;
    logic                 cfg_overlap;
    logic                 cnt_clr;
    logic                 z;
    logic                 z_q;
    logic [CNT_W-1:0]     match_count;
    logic                 cfg_err;

    modport master (
        output x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  z, z_q, match_count, cfg_err
    );

    modport slave (
        input  x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output z, z_q, match_count, cfg_err
    );
endinterface

// File: rtl/seq_detector_prog.sv
// ----------------------------------------------------------------------------
// seq_detector_prog
//   Runtime-programmable serial pattern detector. Matches a pattern of
//   1..MAX_LEN bits against the qualified serial stream, in overlapping or
//   non-overlapping mode, and keeps a saturating match counter.
//
//   Ports
//     clk   : sole clock, rising edge
//     reset : asynchronous, active-low reset
//     bus   : seq_detector_prog_if.slave
//             x / x_valid           serial bit and its qualifier
//             cfg_load + cfg_*      one-cycle pulse capturing pattern/len/mode
//             cnt_clr               synchronous clear of match_count
//             z                     Mealy match, same cycle as final bit
//             z_q                   z delayed by one clock
//             match_count           saturating match count
//             cfg_err               loaded length illegal, detector disabled
//
//   Pattern ordering: cfg_pattern[cfg_len-1] is the first bit received and
//   cfg_pattern[0] the last, so the history register (newest bit at bit 0)
//   lines up directly with the pattern.
// ----------------------------------------------------------------------------
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_detector_prog_if.slave   bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    // Configuration shadow
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_cfg_err;

    // Stream state
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;

    // Outputs
    logic               r_z_q;
    logic [CNT_W-1:0]   r_count;

    logic [MAX_LEN-1:0] w_cand;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W:0]     w_fill_p1;
    logic               w_fill_ok;
    logic               w_bits_eq;
    logic               w_z;
    logic               w_len_bad;

    // Candidate window: stored history with the live bit appended as newest.
    assign w_cand = {r_hist[MAX_LEN-2:0], bus.x};

    // Only the low r_len positions take part in the compare.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign w_mask[gi] = (r_len > LEN_W'(gi));
        end
    endgenerate

    // One extra bit so fill+1 cannot wrap when fill is saturated.
    assign w_fill_p1 = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
    assign w_fill_ok = (w_fill_p1 >= {1'b0, r_len});
    assign w_bits_eq = (((w_cand ^ r_pattern) & w_mask) == '0);

    // Gating with reset keeps z low while reset is held, independent of
    // whatever the inputs are doing.
    assign w_z = reset & bus.x_valid & ~bus.cfg_load & ~r_cfg_err
               & w_fill_ok & w_bits_eq;

    assign w_len_bad = (bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(MAX_LEN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_ovl     <= 1'b0;
            r_cfg_err <= 1'b1;   // length 0 is illegal until configured
            r_hist    <= '0;
            r_fill    <= '0;
            r_z_q     <= 1'b0;
            r_count   <= '0;
        end else begin
            r_z_q <= w_z;

            // Clear has priority: a match in the same cycle is dropped.
            if (bus.cnt_clr) begin
                r_count <= '0;
            end else if (w_z && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end

            if (bus.cfg_load) begin
                r_pattern <= bus.cfg_pattern;
                r_len     <= bus.cfg_len;
                r_ovl     <= bus.cfg_overlap;
                r_cfg_err <= w_len_bad;
                r_hist    <= '0;
                r_fill    <= '0;
            end else if (bus.x_valid) begin
                if (w_z && !r_ovl) begin
                    // Non-overlapping: the next match needs a full fresh pattern.
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_cand;
                    if (r_fill != LEN_W'(MAX_LEN)) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.z           = w_z;
    assign bus.z_q         = r_z_q;
    assign bus.match_count = r_count;
    assign bus.cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;
    logic clk;
    logic rst_n;
    logic chk_en;
    int   total;
    int   bad;

    // Two detectors share one stimulus: an 8-bit counter for the ordinary
    // count checks and a 2-bit counter for saturation.
    seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(8)) ifa ();
    seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(2)) ifb ();

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifa)
    );

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifb)
    );

    assign ifb.x           = ifa.x;
    assign ifb.x_valid     = ifa.x_valid;
    assign ifb.cfg_load    = ifa.cfg_load;
    assign ifb.cfg_pattern = ifa.cfg_pattern;
    assign ifb.cfg_len     = ifa.cfg_len;
    assign ifb.cfg_overlap = ifa.cfg_overlap;
    assign ifb.cnt_clr     = ifa.cnt_clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: the list of accepted bits since the last clear,
    // compared directly against the configured pattern.
    // ------------------------------------------------------------------
    logic [7:0] m_pat = '0;
    int         m_len = 0;
    logic       m_ovl = 1'b0;
    logic       m_err = 1'b1;
    logic       m_hist[$];
    logic       m_zq  = 1'b0;
    int         m_cnt_a = 0;
    int         m_cnt_b = 0;

    function automatic logic exp_z();
        if (!rst_n || !ifa.x_valid || ifa.cfg_load || m_err) return 1'b0;
        if (m_hist.size() + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            logic b;
            b = (k == 0) ? ifa.x : m_hist[m_hist.size() - k];
            if (b !== m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(negedge rst_n) begin
        m_pat = '0; m_len = 0; m_ovl = 1'b0; m_err = 1'b1;
        m_hist.delete(); m_zq = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            logic ez;
            ez = exp_z();
            m_zq = ez;
            if (ifa.cnt_clr) begin
                m_cnt_a = 0;
                m_cnt_b = 0;
            end else if (ez) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3)   m_cnt_b++;
            end
            if (ifa.cfg_load) begin
                m_pat = ifa.cfg_pattern;
                m_len = int'(ifa.cfg_len);
                m_ovl = ifa.cfg_overlap;
                m_err = (m_len == 0) || (m_len > 8);
                m_hist.delete();
            end else if (ifa.x_valid) begin
                if (ez && !m_ovl) begin
                    m_hist.delete();
                end else begin
                    m_hist.push_back(ifa.x);
                    if (m_hist.size() > 8) void'(m_hist.pop_front());
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic ez;
            ez = exp_z();
            check("z_a",   32'(ifa.z), 32'(ez));
            check("z_b",   32'(ifb.z), 32'(ez));
            check("zq_a",  32'(ifa.z_q), 32'(m_zq));
            check("zq_b",  32'(ifb.z_q), 32'(m_zq));
            check("cnt_a", 32'(ifa.match_count), 32'(m_cnt_a));
            check("cnt_b", 32'(ifb.match_count), 32'(m_cnt_b));
            check("err_a", 32'(ifa.cfg_err), 32'(m_err));
            check("err_b", 32'(ifb.cfg_err), 32'(m_err));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Every task starts and ends 1 time unit after a
    // rising edge.
    // ------------------------------------------------------------------
    task automatic cycle_end(output logic z_seen);
        @(negedge clk);
        z_seen = ifa.z;
        @(posedge clk);
        #1;
        ifa.x_valid  = 1'b0;
        ifa.cfg_load = 1'b0;
        ifa.cnt_clr  = 1'b0;
        ifa.x        = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        logic zs;
        ifa.cfg_pattern = pat;
        ifa.cfg_len     = len;
        ifa.cfg_overlap = ovl;
        ifa.cfg_load    = 1'b1;
        cycle_end(zs);
    endtask

    task automatic bit_in(input logic b, input logic clr, output logic z_seen);
        ifa.x       = b;
        ifa.x_valid = 1'b1;
        ifa.cnt_clr = clr;
        cycle_end(z_seen);
    endtask

    task automatic idle(input int n);
        logic zs;
        for (int i = 0; i < n; i++) cycle_end(zs);
    endtask

    task automatic clr();
        logic zs;
        ifa.cnt_clr = 1'b1;
        cycle_end(zs);
    endtask

    // bits[n-1] is sent first; hits[i] records z for the i-th bit sent.
    task automatic stream(input logic [15:0] bits, input int n, output logic [15:0] hits);
        logic zs;
        hits = '0;
        for (int i = 0; i < n; i++) begin
            bit_in(bits[n-1-i], 1'b0, zs);
            hits[i] = zs;
        end
    endtask

    logic [15:0] hits;
    logic        zs;
    logic [1:0]  sat_exp [5];

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        rst_n = 1'b1;
        ifa.x = 0; ifa.x_valid = 0; ifa.cfg_load = 0; ifa.cfg_pattern = '0;
        ifa.cfg_len = '0; ifa.cfg_overlap = 0; ifa.cnt_clr = 0;
        #3 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_err", 32'(ifa.cfg_err), 32'd1);
        check("rst_cnt", 32'(ifa.match_count), 32'd0);
        check("rst_zq",  32'(ifa.z_q), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Overlapping 0110
        cfg(8'b0000_0110, 4'd4, 1'b1);
        stream(16'b0110110, 7, hits);
        check("ovl_hits", 32'(hits), 32'h0048);
        check("ovl_cnt",  32'(ifa.match_count), 32'd2);

        // Non-overlapping vs overlapping 11
        clr();
        cfg(8'b0000_0011, 4'd2, 1'b0);
        stream(16'b11111, 5, hits);
        check("novl_hits", 32'(hits), 32'h000A);
        check("novl_cnt",  32'(ifa.match_count), 32'd2);
        clr();
        cfg(8'b0000_0011, 4'd2, 1'b1);
        stream(16'b11111, 5, hits);
        check("ovl11_hits",  32'(hits), 32'h001E);
        check("ovl11_cnt",   32'(ifa.match_count), 32'd4);
        check("ovl11_cnt_b", 32'(ifb.match_count), 32'd3);

        // Gaps in x_valid
        clr();
        cfg(8'b0000_0110, 4'd4, 1'b1);
        hits = '0;
        bit_in(1'b0, 1'b0, zs); hits[0] = zs; idle(2);
        bit_in(1'b1, 1'b0, zs); hits[1] = zs; idle(1);
        bit_in(1'b1, 1'b0, zs); hits[2] = zs; idle(3);
        bit_in(1'b0, 1'b0, zs); hits[3] = zs; idle(1);
        check("gap_hits", 32'(hits), 32'h0008);

        // Illegal lengths, then reload
        cfg(8'b0000_0101, 4'd0, 1'b1);
        check("len0_err", 32'(ifa.cfg_err), 32'd1);
        stream(16'b10101, 5, hits);
        check("len0_hits", 32'(hits), 32'h0000);
        cfg(8'b0000_0101, 4'd9, 1'b1);
        check("len9_err", 32'(ifa.cfg_err), 32'd1);
        stream(16'b10101, 5, hits);
        check("len9_hits", 32'(hits), 32'h0000);
        cfg(8'b0000_0101, 4'd3, 1'b1);
        check("len3_err", 32'(ifa.cfg_err), 32'd0);
        stream(16'b10101, 5, hits);
        check("len3_hits", 32'(hits), 32'h0014);
        stream(16'b10, 2, hits);
        check("pre_ld_hits", 32'(hits), 32'h0000);
        // Load coincident with a would-be final bit: bit is discarded.
        ifa.x = 1'b1; ifa.x_valid = 1'b1;
        ifa.cfg_pattern = 8'b0000_0101; ifa.cfg_len = 4'd3; ifa.cfg_overlap = 1'b1;
        ifa.cfg_load = 1'b1;
        cycle_end(zs);
        check("ld_coinc_z", 32'(zs), 32'd0);
        stream(16'b101, 3, hits);
        check("post_ld_hits", 32'(hits), 32'h0004);

        // Saturation of the 2-bit counter, then clear against a match
        clr();
        cfg(8'b0000_0001, 4'd1, 1'b1);
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        for (int i = 0; i < 5; i++) begin
            bit_in(1'b1, 1'b0, zs);
            check("sat_z",   32'(zs), 32'd1);
            check("sat_cnt", 32'(ifb.match_count), 32'(sat_exp[i]));
        end
        check("sat_cnt_a", 32'(ifa.match_count), 32'd5);
        bit_in(1'b1, 1'b1, zs);
        check("clr_win_z",   32'(zs), 32'd1);
        check("clr_win_a",   32'(ifa.match_count), 32'd0);
        check("clr_win_b",   32'(ifb.match_count), 32'd0);

        // Reset in the middle of a pattern
        cfg(8'b0000_0110, 4'd4, 1'b1);
        stream(16'b0110, 4, hits);
        check("pre_rst_hits", 32'(hits), 32'h0008);
        check("pre_rst_cnt",  32'(ifa.match_count), 32'd1);
        stream(16'b011, 3, hits);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(ifa.match_count), 32'd0);
        check("mid_rst_err", 32'(ifa.cfg_err), 32'd1);
        check("mid_rst_zq",  32'(ifa.z_q), 32'd0);
        check("mid_rst_z",   32'(ifa.z), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        stream(16'b0110, 4, hits);
        check("post_rst_hits", 32'(hits), 32'h0000);
        check("post_rst_err",  32'(ifa.cfg_err), 32'd1);
        cfg(8'b0000_0110, 4'd4, 1'b1);
        stream(16'b0, 1, hits);
        check("lone0_hits", 32'(hits), 32'h0000);
        stream(16'b110, 3, hits);
        check("rest_hits", 32'(hits), 32'h0004);
        idle(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
